// File: rtl/bus_writeback_demux_pkg.sv
// Shared types and constants for the write-back demux: op encodings, widths, AC index.
package bus_writeback_demux_pkg;

  localparam int unsigned WB_DATA_W   = 24;
  localparam int unsigned WB_ADDR_W   = 3;
  localparam int unsigned WB_NUM_REGS = 8;
  localparam int unsigned AC_IDX      = 0;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_CLR  = 2'd3
  } wb_op_e;

  // True for ops that update a register (and the zero flag) on commit.
  function automatic logic op_writes(wb_op_e op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/bus_writeback_demux_if.sv
// Write request, commit gate and read/status signals of the write-back demux.
interface bus_writeback_demux_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 3
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_op;
  logic [ADDR_W-1:0] wr_dest;
  logic [DATA_W-1:0] wr_data;
  logic              commit_en;
  logic [ADDR_W-1:0] rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ac_out;
  logic              z_flag;
  logic              wb_done;
  logic              busy;

  // Source selector / control unit side.
  modport master (
    output wr_valid, wr_op, wr_dest, wr_data, commit_en, rd_sel,
    input  wr_ready, rd_data, ac_out, z_flag, wb_done, busy
  );

  // Write-back demux side.
  modport slave (
    input  wr_valid, wr_op, wr_dest, wr_data, commit_en, rd_sel,
    output wr_ready, rd_data, ac_out, z_flag, wb_done, busy
  );

endinterface

// File: rtl/bus_writeback_demux_wb_stage_reg.sv
// One-entry staging register: captures a write request and holds it until the
// control unit grants commit. A new entry may be captured on the commit edge.
module bus_writeback_demux_wb_stage_reg
  import bus_writeback_demux_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  wb_op_e            in_op_i,
  input  logic [ADDR_W-1:0] in_dest_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              commit_en_i,
  output logic              busy_o,
  output logic              commit_o,
  output wb_op_e            op_o,
  output logic [ADDR_W-1:0] dest_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  wb_op_e            op_q, op_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  // Handshake and next-entry selection; accept wins over the commit drain.
  always_comb begin
    in_ready_o = !valid_q || commit_en_i;
    accept     = in_valid_i && in_ready_o;
    commit_o   = valid_q && commit_en_i;
    valid_d    = valid_q;
    op_d       = op_q;
    dest_d     = dest_q;
    data_d     = data_q;
    if (commit_o) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      valid_d = 1'b1;
      op_d    = in_op_i;
      dest_d  = in_dest_i;
      data_d  = in_data_i;
    end
  end

  // Entry storage; reset discards any held entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      op_q    <= OP_NOP;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign busy_o = valid_q;
  assign op_o   = op_q;
  assign dest_o = dest_q;
  assign data_o = data_q;

endmodule

// File: rtl/bus_writeback_demux.sv
// Write-back demux: stages one result, commits it into the register bank when the
// control unit allows, and exposes a bypassed registered read port, AC mirror and Z flag.
module bus_writeback_demux
  import bus_writeback_demux_pkg::*;
#(
  parameter int unsigned DATA_W   = WB_DATA_W,
  parameter int unsigned NUM_REGS = WB_NUM_REGS,
  parameter int unsigned ADDR_W   = WB_ADDR_W
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_writeback_demux_if.slave bus
);

  logic              st_ready;
  logic              st_busy;
  logic              st_commit;
  wb_op_e            st_op;
  logic [ADDR_W-1:0] st_dest;
  logic [DATA_W-1:0] st_data;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic              z_q, z_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] old_val, new_val;
  logic              dest_ok, wr_en;

  bus_writeback_demux_wb_stage_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_stage (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (bus.wr_valid),
    .in_ready_o  (st_ready),
    .in_op_i     (wb_op_e'(bus.wr_op)),
    .in_dest_i   (bus.wr_dest),
    .in_data_i   (bus.wr_data),
    .commit_en_i (bus.commit_en),
    .busy_o      (st_busy),
    .commit_o    (st_commit),
    .op_o        (st_op),
    .dest_o      (st_dest),
    .data_o      (st_data)
  );

  // Op ALU, bank update, and read/AC selection from the post-commit bank (bypass).
  always_comb begin
    regs_d  = regs_q;
    old_val = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (st_dest == ADDR_W'(i)) begin
        old_val = regs_q[i];
      end
    end
    new_val = '0;
    unique case (st_op)
      OP_LOAD: new_val = st_data;
      OP_INC:  new_val = old_val + DATA_W'(1);
      default: new_val = '0;
    endcase
    dest_ok = 32'(st_dest) < NUM_REGS;
    wr_en   = st_commit && op_writes(st_op) && dest_ok;
    z_d     = z_q;
    if (wr_en) begin
      z_d = (new_val == '0);
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (st_dest == ADDR_W'(i)) begin
          regs_d[i] = new_val;
        end
      end
    end
    rd_d = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (bus.rd_sel == ADDR_W'(i)) begin
        rd_d = regs_d[i];
      end
    end
    ac_d   = regs_d[AC_IDX];
    done_d = st_commit;
  end

  // Register bank and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      rd_q   <= '0;
      ac_q   <= '0;
      z_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_q   <= rd_d;
      ac_q   <= ac_d;
      z_q    <= z_d;
      done_q <= done_d;
    end
  end

  assign bus.wr_ready = st_ready;
  assign bus.busy     = st_busy;
  assign bus.rd_data  = rd_q;
  assign bus.ac_out   = ac_q;
  assign bus.z_flag   = z_q;
  assign bus.wb_done  = done_q;

endmodule

// File: doc/bus_writeback_demux.md
Name: bus_writeback_demux

Overview:
- Write-back end of the datapath select path: accepts the selected 24-bit result (ALU or bus value) plus a destination/op tag, and routes it into one of the processor's general registers.
- Holds the register bank (R0 = AC) with one-entry staging and a commit gate driven by the control unit; provides a registered read port with same-cycle bypass and a zero flag.
- Sits between the ALU/bus source selector and the register outputs that feed the bus.

Parameters:
- DATA_W, 24, datapath width.
- NUM_REGS, 8, registers in bank (R0 = AC); legal range 2..8.
- ADDR_W, 3, destination/select index width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- wr_valid  in  1  write request present.
- wr_ready  out  1  request accepted this cycle when wr_valid=1.
- wr_op  in  2  0=NOP, 1=LOAD, 2=INC, 3=CLR.
- wr_dest  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  value from source selector (used by LOAD only).
- commit_en  in  1  control-unit permission to apply staged entry.
- rd_sel  in  ADDR_W  read register index.
- rd_data  out  DATA_W  registered read data.
- ac_out  out  DATA_W  direct (registered) copy of R0.
- z_flag  out  1  last committed write value == 0.
- wb_done  out  1  one-cycle pulse when a staged entry commits.
- busy  out  1  staging entry occupied.

Behaviour:
- Reset (rst_n=0 at clk edge): all registers 0, stage empty, rd_data=0, ac_out=0, z_flag=0, wb_done=0, busy=0. Reset mid-operation discards the staged entry with no register write.
- wr_ready = !busy | commit_en (combinational). Accept = wr_valid & wr_ready.
- Accept: stage captures {op, dest, data}; busy=1 from the next cycle.
- Commit (busy & commit_en at the clock edge): applies the staged op.
  - LOAD: R[dest] <= data.
  - INC: R[dest] <= R[dest]+1, modulo 2^DATA_W (0xFFFFFF -> 0x000000).
  - CLR: R[dest] <= 0.
  - NOP: no write.
  - wb_done=1 the following cycle, for exactly 1 cycle.
- Latency: accept at edge N, earliest commit at edge N+1, register visible on ac_out/rd_data after edge N+1.
- Simultaneous commit and accept in the same cycle: old entry commits and the new entry is staged; busy stays 1; no bubble.
- busy=1 & commit_en=0: entry held; wr_ready=0; wr_* inputs ignored.
- z_flag: updated only on LOAD/INC/CLR commits to (new value == 0); holds on NOP or while idle. CLR sets it to 1; INC wrap sets it to 1.
- Out-of-range dest (>= NUM_REGS): no register write, z_flag unchanged, wb_done still pulses.
- rd_data <= R[rd_sel] each cycle. Bypass: if a commit writes R[rd_sel] at the same edge, rd_data takes the new value. Out-of-range rd_sel returns 0.
- ac_out always mirrors R0 after each edge, with the same bypass rule.
- Back-to-back INC on the same register with commit_en=1 continuously: each commit uses the already-updated value (one increment per commit, none lost).

Decomposition:
- Shared package: op encodings (OP_NOP/LOAD/INC/CLR), DATA_W=24, AC index 0.
- One natural sub-module: wb_stage_reg (one-entry staging register with valid/ready and commit_en hold). The register bank, op ALU and read bypass stay in the top module.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with wr_valid=1 -> all outputs 0, no write; after release, wr_ready=1, busy=0.
- LOAD R0=64 then LOAD R3=256, commit_en=1 -> ac_out=64 one cycle after first accept; rd_sel=3 gives rd_data=256; wb_done pulses twice; z_flag=0.
- LOAD R2=0xFFFFFF then INC R2, commit_en=1 -> R2=0, z_flag=1; second INC -> R2=1, z_flag=0.
- commit_en=0 with staged LOAD R1=5 -> busy=1, wr_ready=0, R1 unchanged for 4 cycles; a second request is held off; commit_en=1 -> R1=5, wb_done=1, new request accepted the same cycle.
- rd_sel=4 while committing LOAD R4=0x123456 -> rd_data=0x123456 at that edge (bypass); CLR R4 -> rd_data=0, z_flag=1.
- Reset asserted with busy=1 (staged LOAD R0=99) -> R0 stays 0, busy=0, no wb_done; dest=7 with NUM_REGS=4 -> no write, wb_done pulse only.
